// File: rtl/ooo_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ooo_pkg
//  Description : Shared types and constants for the out-of-order issue stage:
//                the renamed micro-op payload, the issue-queue entry, the
//                functional-unit select codes and default sizes.
//  Revision    : 1.0  initial release
// ============================================================================
package ooo_pkg;

    localparam int DEPTH_DEFAULT = 8;
    localparam int PREG_DEFAULT  = 128;
    localparam int TAG_W         = 7;

    // Functional-unit select codes; each indexes one bit of fu_ready.
    localparam logic [2:0] FU_ALU   = 3'd0;
    localparam logic [2:0] FU_MUL   = 3'd1;
    localparam logic [2:0] FU_DIV   = 3'd2;
    localparam logic [2:0] FU_BR    = 3'd3;
    localparam logic [2:0] FU_CSR   = 3'd4;
    localparam logic [2:0] FU_FPU   = 3'd5;
    localparam logic [2:0] FU_LOAD  = 3'd6;
    localparam logic [2:0] FU_STORE = 3'd7;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [31:0]      imm;
        logic [6:0]       op;
        logic [2:0]       f3;
        logic [6:0]       f7;
        logic [TAG_W-1:0] P_rs1;
        logic [TAG_W-1:0] P_rs2;
        logic [TAG_W-1:0] P_rd;
        logic [2:0]       fu_sel;
        logic [4:0]       rob_idx;
        logic [3:0]       LQ_tail;
        logic [3:0]       SQ_tail;
        logic             jump;
    } payload_t;

    typedef struct packed {
        logic     valid;
        logic     rs1_rdy;
        logic     rs2_rdy;
        payload_t pl;
    } iq_entry_t;

endpackage
`default_nettype wire

// File: rtl/busy_table.sv
`default_nettype none
// ============================================================================
//  Module      : busy_table
//  Description : Physical-register busy bits. One set port (rename of a new
//                destination), one clear port (writeback), a global flush and
//                two combinational readiness ports that already account for a
//                same-cycle writeback of the tag being read.
//  Ports       : clk, rst          clock, async active-high reset
//                i_set_en/_tag     mark a tag busy at the next edge
//                i_clr_en/_tag     mark a tag ready at the next edge
//                i_flush           clear every bit at the next edge
//                i_rd{0,1}_tag     source tags to look up
//                o_rd{0,1}_rdy     source is available (or being woken now)
//  Revision    : 1.0  initial release
// ============================================================================
module busy_table #(
    parameter int PREG  = 128,
    parameter int TAG_W = $clog2(PREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_set_en,
    input  logic [TAG_W-1:0] i_set_tag,
    input  logic             i_clr_en,
    input  logic [TAG_W-1:0] i_clr_tag,
    input  logic             i_flush,
    input  logic [TAG_W-1:0] i_rd0_tag,
    input  logic [TAG_W-1:0] i_rd1_tag,
    output logic             o_rd0_rdy,
    output logic             o_rd1_rdy
);

    logic [PREG-1:0] r_busy;
    logic [PREG-1:0] w_busy_nxt;

    // Clear is applied before set so a rename of a tag that is being written
    // back in the same cycle leaves the tag busy for the new producer.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_flush) begin
            w_busy_nxt = '0;
        end else begin
            if (i_clr_en) w_busy_nxt[i_clr_tag] = 1'b0;
            if (i_set_en && (i_set_tag != '0)) w_busy_nxt[i_set_tag] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    assign o_rd0_rdy = !r_busy[i_rd0_tag] || (i_clr_en && (i_clr_tag == i_rd0_tag))
                       || (i_rd0_tag == '0);
    assign o_rd1_rdy = !r_busy[i_rd1_tag] || (i_clr_en && (i_clr_tag == i_rd1_tag))
                       || (i_rd1_tag == '0);

endmodule
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : issue_queue
//  Description : Age-ordered collapsing issue queue. Accepts one renamed
//                micro-op per cycle, wakes sources on writeback broadcasts and
//                issues the oldest ready op whose functional unit is free.
//  Ports       : clk, rst          clock, async active-high reset
//                DC_valid/in_data  micro-op from dispatch
//                IS_ready          queue has a free slot (count < DEPTH)
//                wb_valid/wb_P_rd  writeback wakeup broadcast
//                fu_ready          per-fu_sel accept
//                mispredict        flush queue and busy table
//                IS_valid/out_data issued micro-op (payload zero when idle)
//  Revision    : 1.0  initial release
// ============================================================================
module issue_queue
    import ooo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int PREG  = PREG_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             DC_valid,
    input  payload_t         DC_in_data,
    output logic             IS_ready,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_P_rd,
    input  logic [7:0]       fu_ready,
    input  logic             mispredict,
    output logic             IS_valid,
    output payload_t         IS_out_data
);

    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    iq_entry_t          r_q [DEPTH];
    logic [c_CNT_W-1:0] r_count;

    iq_entry_t          w_ext   [DEPTH+1];
    iq_entry_t          w_q_nxt [DEPTH];
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [c_CNT_W-1:0] w_ins_pos;
    logic [c_CNT_W-1:0] w_sel_idx;
    logic               w_sel_found;
    logic               w_issue;
    logic               w_ins;
    logic               w_rs1_rdy;
    logic               w_rs2_rdy;
    payload_t           w_sel_pl;

    busy_table #(
        .PREG  (PREG),
        .TAG_W (TAG_W)
    ) u_busy (
        .clk       (clk),
        .rst       (rst),
        .i_set_en  (w_ins),
        .i_set_tag (DC_in_data.P_rd),
        .i_clr_en  (wb_valid),
        .i_clr_tag (wb_P_rd),
        .i_flush   (mispredict),
        .i_rd0_tag (DC_in_data.P_rs1),
        .i_rd1_tag (DC_in_data.P_rs2),
        .o_rd0_rdy (w_rs1_rdy),
        .o_rd1_rdy (w_rs2_rdy)
    );

    assign IS_ready = (r_count < c_CNT_W'(DEPTH));
    assign w_ins    = DC_valid && IS_ready && !mispredict;

    // Priority encoder over registered entries only: a wakeup seen this cycle
    // becomes visible to select at the next edge.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_pl    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_q[i].valid && r_q[i].rs1_rdy && r_q[i].rs2_rdy && fu_ready[r_q[i].pl.fu_sel]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = c_CNT_W'(i);
                w_sel_pl    = r_q[i].pl;
            end
        end
    end

    assign w_issue     = w_sel_found && !mispredict;
    assign IS_valid    = w_issue;
    assign IS_out_data = w_issue ? w_sel_pl : '0;
    assign w_ins_pos   = r_count - c_CNT_W'(w_issue);
    assign w_count_nxt = r_count + c_CNT_W'(w_ins) - c_CNT_W'(w_issue);

    // Next queue image: apply wakeup, collapse over the issued slot, then
    // drop the new op into the first free slot after the collapse.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ext[i] = r_q[i];
            if (wb_valid && (r_q[i].pl.P_rs1 == wb_P_rd)) w_ext[i].rs1_rdy = 1'b1;
            if (wb_valid && (r_q[i].pl.P_rs2 == wb_P_rd)) w_ext[i].rs2_rdy = 1'b1;
        end
        w_ext[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_issue && (c_CNT_W'(i) >= w_sel_idx)) w_q_nxt[i] = w_ext[i+1];
            else                                       w_q_nxt[i] = w_ext[i];
            if (w_ins && (c_CNT_W'(i) == w_ins_pos)) begin
                w_q_nxt[i] = '{valid: 1'b1, rs1_rdy: w_rs1_rdy, rs2_rdy: w_rs2_rdy, pl: DC_in_data};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
        end else if (mispredict) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
        end else begin
            r_count <= w_count_nxt;
            for (int i = 0; i < DEPTH; i++) r_q[i] <= w_q_nxt[i];
        end
    end

endmodule
`default_nettype wire
